// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage : sub_pkg

// File: rtl/full_sub1.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow is generated when a=0,b=1, or propagated when a==b.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_sub1

// File: rtl/serial_sub32.sv
// Bit-serial subtractor computing a - b one bit per clock, LSB first.
// Operands are captured on an accepted start, the result is published on
// the edge that enters DONE and then held until the next result.
// Optional feature: define SUB_OVERFLOW_EN to add the signed overflow output.
module serial_sub32
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_e       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;

`ifdef SUB_OVERFLOW_EN
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  // Single shared bit slice, fed from the operand LSBs and running borrow.
  logic bit_d;
  logic bit_bout;

  full_sub1 u_bit (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // The bit just produced completes the result once the counter has seen
  // WIDTH-1 earlier bits.
  logic last_bit;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // A start is honoured whenever the engine is not busy (IDLE or DONE).
  logic accept;
  assign accept = start && (state_q != RUN);

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      RUN: begin
        busy    = 1'b1;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {bit_d, res_q[WIDTH-1:1]};
        br_d    = bit_bout;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = DONE;
          // Publish directly from the incoming bit so the outputs change
          // on the same edge that enters DONE.
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
`ifdef SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture is shared by IDLE and the back-to-back DONE case.
    if (accept) begin
      state_d = RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      res_d   = '0;
      br_d    = 1'b0;
      cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits captured at start and the published overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule : serial_sub32

// File: tb/tb_serial_sub32.sv
// Scoreboard bench for serial_sub32: the driver pushes expected results from
// an arithmetic reference model, a monitor pops them whenever done pulses and
// also checks output hold, busy/done exclusivity and latency.
// Build with SUB_OVERFLOW_EN defined to exercise the overflow output.
module tb_serial_sub32;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf_obs;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow (ovf_obs)
`endif
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf_obs = 1'b0;
`endif

  // Reference: integer subtraction, unsigned compare, signed range test.
  function automatic exp_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r  = sx - sy;
    longint hi = (longint'(1) << (W - 1)) - 1;
    longint lo = -(longint'(1) << (W - 1));
    e.diff   = x - y;
    e.borrow = (x < y);
`ifdef SUB_OVERFLOW_EN
    e.ovf    = (r > hi) || (r < lo);
`else
    e.ovf    = 1'b0;
`endif
    e.cyc    = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic [W-1:0] held_diff = '0;
  logic         held_b    = 1'b0;
  logic         held_o    = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        held_diff = '0;
        held_b    = 1'b0;
        held_o    = 1'b0;
      end else begin
        check("busy_done_exclusive", 64'(busy & done), 64'd0);
        if (done) begin
          if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            check("diff",     64'(diff),    64'(e.diff));
            check("borrow",   64'(borrow),  64'(e.borrow));
            check("overflow", 64'(ovf_obs), 64'(e.ovf));
            check("latency",  64'(cyc),     64'(e.cyc + W));
            $display("result diff=%08h borrow=%0d ovf=%0d at cycle %0d", diff, borrow, ovf_obs, cyc);
          end
          held_diff = diff;
          held_b    = borrow;
          held_o    = ovf_obs;
        end else begin
          check("hold_diff",     64'(diff),    64'(held_diff));
          check("hold_borrow",   64'(borrow),  64'(held_b));
          check("hold_overflow", 64'(ovf_obs), 64'(held_o));
        end
      end
    end
  end

  // Called and returning just after a falling edge.
  task automatic issue_exp(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    if (busy) begin
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
    end
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    q.push_back(e);
    check("accept_busy", 64'(busy), 64'd1);
    $display("issue a=%08h b=%08h at cycle %0d", x, y, cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    issue_exp(x, y, ref_sub(x, y));
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: got done=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},     64'(busy),    64'd0);
    check({tag, "_done"},     64'(done),    64'd0);
    check({tag, "_diff"},     64'(diff),    64'd0);
    check({tag, "_borrow"},   64'(borrow),  64'd0);
    check({tag, "_overflow"}, 64'(ovf_obs), 64'd0);
  endtask

  initial begin
    logic [W-1:0] x, y, s;
    exp_t         e;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Directed cases.
    issue(32'd10, 32'd1);          wait_done();
    issue(32'd0, 32'd1);           wait_done();
    issue(32'h8000_0000, 32'd1);   wait_done();
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF); wait_done();

    // Start during RUN is ignored; only one result may appear.
    issue(32'd5, 32'd3);
    repeat (8) @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Back-to-back: new start accepted in the DONE cycle.
    issue(32'd50, 32'd8);
    wait_done();
    issue(32'd1010, 32'd10);
    wait_done();
    repeat (3) @(negedge clk);

    // Reset mid-operation discards the result.
    issue(32'd1234, 32'd5);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd7, 32'd7);
    wait_done();

    // Randomized operations, including a+b,b round trips and equal operands.
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          s      = x + y;
          e      = ref_sub(s, y);
          e.diff = x;
          issue_exp(s, y, e);
        end
        1: issue(x, x);
        2: issue(x & 32'h0000_000F, y & 32'h0000_000F);
        default: issue(x, y);
      endcase
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_sub32

// File: doc/serial_sub32.md
# serial_sub32

Bit-serial 32-bit subtractor computing `a - b` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse arithmetic path of the team's combinational 32-bit adder. It is used where area matters more than latency, and as a cross-check engine: feeding it `(a + b, b)` must return `a`. Operands are captured on start, and the result is held stable until the next accepted start.

## Interface
- `WIDTH`, default 32, operand and result width (≥ 2).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; accepted only when `busy` = 0.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `busy`  out  1  high while the subtraction is running.
- `done`  out  1  one-cycle pulse; `diff`/`borrow` are valid from this cycle onward.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  out  1  unsigned borrow-out (1 when `a < b` unsigned).
- `overflow`  out  1  signed two's-complement overflow; present only with `SUB_OVERFLOW_EN`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE, start=1:** load `a` and `b` into shift registers, clear the internal borrow, clear the bit counter, go to RUN.
- **IDLE, start=0:** stay in IDLE.
- **RUN:** each cycle processes the LSB pair (a0, b0, br).
  - Difference bit d = a0 ^ b0 ^ br.
  - Next borrow br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result register; both operand registers shift right.
  - The counter increments. After the WIDTH-th bit, go to DONE.
- **DONE:** `done` = 1 for exactly one cycle.
  - Update `diff` and `borrow` from the result register and final borrow on the edge that enters DONE.
  - Next state is IDLE. If `start` = 1 in DONE, accept it instead: load new operands and go to RUN (back-to-back).
- `start` while in RUN is ignored. It is not queued.
- `diff`/`borrow`/`overflow` hold their last values until the next DONE. They do not change during RUN.
- **Arithmetic:** the counter is $clog2(WIDTH+1) bits wide. No sign extension. The result wraps modulo 2^WIDTH.
- **Reset mid-operation:** immediate return to IDLE. All outputs go to 0 and the operation is discarded.

## Timing
- Reset values are 0 for `busy`, `done`, `diff`, `borrow` and `overflow`.
- If start is accepted at edge E0:
  - `busy` = 1 from after E0 through edge E0+WIDTH.
  - `done` = 1 in the cycle after E0+WIDTH, so latency is WIDTH+1 cycles from acceptance.
- `busy` = 0 in the DONE cycle, so a new start can be accepted there. Throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high at the same time.

## Configuration
- **`SUB_OVERFLOW_EN` defined:**
  - The `overflow` port exists.
  - Its value is `(a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB])`, using the sampled operand MSBs, which are latched at start.
  - It updates with `diff`.
- **Not defined:** no `overflow` port, no MSB latch registers. Behaviour is otherwise identical.

## Structure
- **Package `sub_pkg`:** state enum (IDLE, RUN, DONE) and `SUB_WIDTH_DEFAULT = 32`.
- **Sub-module `full_sub1`:** combinational one-bit full subtractor (a, b, bin → d, bout). It is instantiated once and reused every RUN cycle.
- **Top module:** FSM, counter, shift registers and output registers.

## Test plan
- a=10, b=1 → after 33 cycles `done` pulses with diff=9, borrow=0, overflow=0.
- a=0, b=1 → diff=32'hFFFFFFFF, borrow=1, overflow=0.
- a=32'h80000000, b=1 → diff=32'h7FFFFFFF, borrow=0, overflow=1 (macro on).
- Start (a=5, b=3); pulse start with a=100, b=1 at cycle 10 while busy → result 2 only, no second `done`.
- Back-to-back: start asserted in the DONE cycle with a=1010, b=10 → first result held, second `done` pulses 33 cycles later with diff=1000.
- Assert `rst` at cycle 15 of RUN → outputs 0 in the same cycle, no `done`. A subsequent start (a=7, b=7) gives diff=0, borrow=0.
